// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder and its address map.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  // kseg0/kseg1 fold onto the low 512 MB of physical space
  localparam logic [1:0]  KSEG_SEL  = 2'b10;
  localparam logic [31:0] KSEG_MASK = 32'h1fff_ffff;

  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_FLAG  = 1'b0;

endpackage

// File: rtl/inst_fetch_resp_if.sv
// SRAM-like instruction-memory read bus (req/addr_ok/data_ok).
// Handshake: req is held with a stable addr until addr_ok; one data_ok returns rdata per accepted address.
interface inst_fetch_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, input addr_ok, data_ok, rdata);
  modport slave  (input req, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/fetch_addr_map.sv
// Virtual-to-physical address map for kseg0/kseg1; purely combinational, shared with the data side.
module fetch_addr_map
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] vaddr,
  output logic [ADDR_W-1:0] paddr
);

  always_comb begin
    paddr = vaddr;
    if (vaddr[ADDR_W-1 -: 2] == KSEG_SEL)
      paddr = vaddr & ADDR_W'(KSEG_MASK);
  end

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: one outstanding read, result held until decode accepts it.
// Optional misaligned-fetch trap: define FETCH_ALIGN_CHECK_EN.
module inst_fetch_resp
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_ready,
  input  logic                     flush,
  output logic                     inst_valid,
  output logic [DATA_W-1:0]        inst_rdata,
  output logic [ADDR_W-1:0]        inst_pc,
  input  logic                     inst_accept,
  output logic                     inst_adel,
  inst_fetch_resp_if.master        bus,
  output state_t                   dbg_state
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t            state_q;
  logic              req_q;
  logic              valid_q;
  logic              discard_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] map_paddr;
  logic              take;

  fetch_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
    .vaddr (fetch_addr),
    .paddr (map_paddr)
  );

  assign fetch_ready = ((state_q == IDLE) || ((state_q == HOLD) && inst_accept)) && !flush;
  assign take        = fetch_req && fetch_ready;

`ifdef FETCH_ALIGN_CHECK_EN
  logic adel_q;
  logic mis_fetch;
  assign mis_fetch = |fetch_addr[1:0];
  assign inst_adel = adel_q;
`else
  assign inst_adel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RST_STATE;
      req_q      <= RST_FLAG;
      valid_q    <= RST_FLAG;
      discard_q  <= RST_FLAG;
      bus_addr_q <= '0;
      pc_q       <= '0;
      rdata_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_q     <= RST_FLAG;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (flush) discard_q <= 1'b1;
          if (bus.addr_ok) begin
            req_q   <= 1'b0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bus.data_ok) begin
            // a flushed transaction still drains from the bus, but its data is dropped
            discard_q <= 1'b0;
            if (discard_q || flush) begin
              state_q <= IDLE;
            end else begin
              rdata_q <= bus.rdata;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || inst_accept) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
`ifdef FETCH_ALIGN_CHECK_EN
            adel_q  <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase

      // a new fetch overrides the HOLD->IDLE exit so back-to-back fetches have no gap
      if (take) begin
        pc_q <= fetch_addr;
`ifdef FETCH_ALIGN_CHECK_EN
        if (mis_fetch) begin
          rdata_q <= '0;
          valid_q <= 1'b1;
          adel_q  <= 1'b1;
          state_q <= HOLD;
        end else begin
          bus_addr_q <= map_paddr & WORD_MASK;
          req_q      <= 1'b1;
          valid_q    <= 1'b0;
          adel_q     <= 1'b0;
          state_q    <= ADDR;
        end
`else
        bus_addr_q <= map_paddr & WORD_MASK;
        req_q      <= 1'b1;
        valid_q    <= 1'b0;
        state_q    <= ADDR;
`endif
      end
    end
  end

  assign bus.req    = req_q;
  assign bus.addr   = bus_addr_q;
  assign inst_valid = valid_q;
  assign inst_rdata = rdata_q;
  assign inst_pc    = pc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp; covers FETCH_ALIGN_CHECK_EN in either build.
module tb_inst_fetch_resp;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst_rdata;
  logic [31:0] inst_pc;
  logic        inst_accept;
  logic        inst_adel;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;

  inst_fetch_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch_resp #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .inst_valid  (inst_valid),
    .inst_rdata  (inst_rdata),
    .inst_pc     (inst_pc),
    .inst_accept (inst_accept),
    .inst_adel   (inst_adel),
    .bus         (bus),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0; inst_accept = 1'b0;
    bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = '0;

    repeat (2) smp();
    chk("rst_req",   64'(bus.req),     64'd0);
    chk("rst_addr",  64'(bus.addr),    64'd0);
    chk("rst_valid", 64'(inst_valid),  64'd0);
    chk("rst_pc",    64'(inst_pc),     64'd0);
    chk("rst_rdata", 64'(inst_rdata),  64'd0);
    chk("rst_adel",  64'(inst_adel),   64'd0);
    chk("rst_ready", 64'(fetch_ready), 64'd1);
    rst = 1'b1;
    tick();

    // boot fetch, minimum latency
    fetch_req = 1'b1; fetch_addr = 32'hbfc0_0000;
    smp(); chk("t1_ready", 64'(fetch_ready), 64'd1);
    tick();
    fetch_req = 1'b0; bus.addr_ok = 1'b1;
    smp();
    chk("t1_req",      64'(bus.req),     64'd1);
    chk("t1_addr",     64'(bus.addr),    64'h1fc0_0000);
    chk("t1_busy",     64'(fetch_ready), 64'd0);
    tick();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h3c1d_8000;
    smp();
    chk("t1_req_drop", 64'(bus.req),     64'd0);
    chk("t1_novalid",  64'(inst_valid),  64'd0);
    tick();
    bus.data_ok = 1'b0; bus.rdata = 32'h0;

    // hold without accept for 3 cycles
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("hold_valid", 64'(inst_valid),  64'd1);
      chk("hold_pc",    64'(inst_pc),     64'hbfc0_0000);
      chk("hold_rdata", 64'(inst_rdata),  64'h3c1d_8000);
      chk("hold_ready", 64'(fetch_ready), 64'd0);
      tick();
    end

    // accept together with next fetch: no idle gap
    inst_accept = 1'b1; fetch_req = 1'b1; fetch_addr = 32'hbfc0_0004;
    smp(); chk("b2b_ready", 64'(fetch_ready), 64'd1);
    tick();
    inst_accept = 1'b0; fetch_req = 1'b0; bus.addr_ok = 1'b1;
    smp();
    chk("b2b_req",   64'(bus.req),    64'd1);
    chk("b2b_addr",  64'(bus.addr),   64'h1fc0_0004);
    chk("b2b_valid", 64'(inst_valid), 64'd0);
    tick();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h2408_0001;
    tick();
    bus.data_ok = 1'b0;
    smp();
    chk("b2b_hvalid", 64'(inst_valid), 64'd1);
    chk("b2b_pc",     64'(inst_pc),    64'hbfc0_0004);
    chk("b2b_rdata",  64'(inst_rdata), 64'h2408_0001);
    inst_accept = 1'b1;
    tick();
    inst_accept = 1'b0;
    smp();
    chk("acc_valid", 64'(inst_valid),  64'd0);
    chk("acc_ready", 64'(fetch_ready), 64'd1);
    tick();

    // addr_ok delayed 4 cycles; competing fetch_req and stray data_ok must be ignored
    fetch_req = 1'b1; fetch_addr = 32'h8000_1000;
    tick();
    fetch_addr = 32'hbfc0_0010; bus.data_ok = 1'b1; bus.rdata = 32'h5555_aaaa;
    for (int i = 0; i < 5; i++) begin
      bus.addr_ok = (i == 4);
      smp();
      chk("wait_req",   64'(bus.req),     64'd1);
      chk("wait_addr",  64'(bus.addr),    64'h0000_1000);
      chk("wait_ready", 64'(fetch_ready), 64'd0);
      tick();
    end
    fetch_req = 1'b0; bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h1111_2222;
    smp(); chk("wait_data_req", 64'(bus.req), 64'd0);
    tick();
    bus.data_ok = 1'b0;
    smp();
    chk("wait_valid", 64'(inst_valid), 64'd1);
    chk("wait_pc",    64'(inst_pc),    64'h8000_1000);
    chk("wait_rdata", 64'(inst_rdata), 64'h1111_2222);

    // flush in HOLD
    flush = 1'b1;
    smp(); chk("hflush_ready", 64'(fetch_ready), 64'd0);
    tick();
    flush = 1'b0;
    smp();
    chk("hflush_valid", 64'(inst_valid),  64'd0);
    chk("hflush_ready", 64'(fetch_ready), 64'd1);
    tick();

    // flush in DATA: data discarded
    fetch_req = 1'b1; fetch_addr = 32'h0040_0000;
    tick();
    fetch_req = 1'b0; bus.addr_ok = 1'b1;
    smp(); chk("dflush_addr", 64'(bus.addr), 64'h0040_0000);
    tick();
    bus.addr_ok = 1'b0; flush = 1'b1;
    smp(); chk("dflush_state", 64'(dbg_state), 64'(DATA));
    tick();
    flush = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hdead_beef;
    smp(); chk("dflush_v0", 64'(inst_valid), 64'd0);
    tick();
    bus.data_ok = 1'b0;
    smp();
    chk("dflush_v1",    64'(inst_valid),  64'd0);
    chk("dflush_ready", 64'(fetch_ready), 64'd1);
    chk("dflush_idle",  64'(dbg_state),   64'(IDLE));
    chk("dflush_rdata", 64'(inst_rdata),  64'h1111_2222);
    tick();
    smp(); chk("dflush_v2", 64'(inst_valid), 64'd0);
    tick();

    // flush and fetch_req together in IDLE: not accepted
    fetch_req = 1'b1; flush = 1'b1; fetch_addr = 32'hbfc0_0020;
    smp(); chk("iflush_ready", 64'(fetch_ready), 64'd0);
    tick();
    fetch_req = 1'b0; flush = 1'b0;
    smp();
    chk("iflush_req",   64'(bus.req),   64'd0);
    chk("iflush_state", 64'(dbg_state), 64'(IDLE));
    tick();

    // reset in ADDR
    fetch_req = 1'b1; fetch_addr = 32'hbfc0_0008;
    tick();
    fetch_req = 1'b0;
    smp(); chk("mrst_req_before", 64'(bus.req), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("mrst_req",   64'(bus.req),    64'd0);
    chk("mrst_addr",  64'(bus.addr),   64'd0);
    chk("mrst_pc",    64'(inst_pc),    64'd0);
    chk("mrst_rdata", 64'(inst_rdata), 64'd0);
    chk("mrst_valid", 64'(inst_valid), 64'd0);
    smp();
    rst = 1'b1;
    #1 chk("mrst_ready", 64'(fetch_ready), 64'd1);
    tick();

    // misaligned fetch
    fetch_req = 1'b1; fetch_addr = 32'hbfc0_0002;
    tick();
    fetch_req = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    smp();
    chk("adel_req",   64'(bus.req),    64'd0);
    chk("adel_valid", 64'(inst_valid), 64'd1);
    chk("adel_flag",  64'(inst_adel),  64'd1);
    chk("adel_rdata", 64'(inst_rdata), 64'd0);
    chk("adel_pc",    64'(inst_pc),    64'hbfc0_0002);
    inst_accept = 1'b1;
    tick();
    inst_accept = 1'b0;
    smp();
    chk("adel_clear", 64'(inst_valid), 64'd0);
`else
    bus.addr_ok = 1'b1;
    smp();
    chk("mis_req",  64'(bus.req),   64'd1);
    chk("mis_addr", 64'(bus.addr),  64'h1fc0_0000);
    chk("mis_adel", 64'(inst_adel), 64'd0);
    tick();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h0123_4567;
    tick();
    bus.data_ok = 1'b0;
    smp();
    chk("mis_valid", 64'(inst_valid), 64'd1);
    chk("mis_pc",    64'(inst_pc),    64'hbfc0_0002);
    chk("mis_rdata", 64'(inst_rdata), 64'h0123_4567);
    chk("mis_adel2", 64'(inst_adel),  64'd0);
    inst_accept = 1'b1;
    tick();
    inst_accept = 1'b0;
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
